// File: rtl/spi_mem_slave.sv
// SPI mode 0 slave in front of a 2**ADDR_W x DATA_W register-array memory.
// Define SPI_MEM_BURST_EN to enable multi-word transfers with address auto-increment.
module spi_mem_slave #(
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sclk_pin,
  input  logic       cs_pin,
  input  logic       mosi_pin,
  output logic       miso_pin,
  output logic       miso_oe,
  output logic       busy,
  output logic [3:0] leds
);

`ifdef SPI_MEM_BURST_EN
  localparam bit Burst = 1'b1;
`else
  localparam bit Burst = 1'b0;
`endif

  localparam int unsigned Depth  = 2 ** ADDR_W;
  localparam int unsigned CntMax = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] CmdLast  = CntW'(ADDR_W);
  localparam logic [CntW-1:0] DataLast = CntW'(DATA_W - 1);
  localparam logic [CntW-1:0] DataFull = CntW'(DATA_W);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StGetCmd   = 3'd1,
    StRdLoad   = 3'd2,
    StRdShift  = 3'd3,
    StWrShift  = 3'd4,
    StWrCommit = 3'd5,
    StDone     = 3'd6
  } state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, rise_q, fall_q;
  logic                   sclk_s, cs_s, mosi_s;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, addr_inc;
  logic [DATA_W-1:0]   shift_q, shift_d, rd_cur, rd_next;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                miso_q, miso_d, oe_q, oe_d;
  logic                mem_we;

  logic [DATA_W-1:0]   mem [Depth];

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // CS synchroniser resets to deasserted so busy comes out of reset low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_pin};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_pin};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_pin};
      sclk_prev_q <= sclk_s;
      rise_q      <= sclk_s & ~sclk_prev_q;
      fall_q      <= ~sclk_s & sclk_prev_q;
    end
  end

  assign addr_inc = addr_q + 1'b1;
  assign rd_cur   = mem[addr_q];
  assign rd_next  = mem[addr_inc];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    miso_d  = miso_q;
    oe_d    = oe_q;
    // A commit that has started always lands, even if CS rises in the same clk.
    mem_we  = (state_q == StWrCommit);

    if (cs_s) begin
      state_d = StIdle;
      oe_d    = 1'b0;
      miso_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StGetCmd;
          cnt_d   = '0;
        end
        StGetCmd: begin
          if (rise_q) begin
            if (cnt_q == CmdLast) begin
              cnt_d   = '0;
              state_d = mosi_s ? StRdLoad : StWrShift;
            end else begin
              addr_d = {addr_q[ADDR_W-2:0], mosi_s};
              cnt_d  = cnt_q + 1'b1;
            end
          end
        end
        StRdLoad: begin
          shift_d = rd_cur;
          oe_d    = 1'b1;
          cnt_d   = '0;
          state_d = StRdShift;
        end
        StRdShift: begin
          if (fall_q) begin
            if (cnt_q == DataFull) begin
              if (Burst) begin
                // Reload and present the next word's MSB on this same fall.
                addr_d  = addr_inc;
                miso_d  = rd_next[DATA_W-1];
                shift_d = rd_next << 1;
                cnt_d   = CntW'(1);
              end else begin
                state_d = StDone;
                oe_d    = 1'b0;
                miso_d  = 1'b0;
              end
            end else begin
              miso_d  = shift_q[DATA_W-1];
              shift_d = shift_q << 1;
              cnt_d   = cnt_q + 1'b1;
            end
          end
        end
        StWrShift: begin
          if (rise_q) begin
            shift_d = {shift_q[DATA_W-2:0], mosi_s};
            if (cnt_q == DataLast) begin
              cnt_d   = '0;
              state_d = StWrCommit;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        StWrCommit: begin
          if (Burst) begin
            addr_d  = addr_inc;
            state_d = StWrShift;
          end else begin
            state_d = StDone;
          end
        end
        StDone: begin
          oe_d   = 1'b0;
          miso_d = 1'b0;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      miso_q  <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      miso_q  <= miso_d;
      oe_q    <= oe_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q] <= shift_q;
  end

  assign miso_pin = miso_q & oe_q;
  assign miso_oe  = oe_q;
  assign busy     = ~cs_s;
  assign leds     = {oe_q, state_q};

endmodule

// File: doc/spi_mem_slave.md
Name: spi_mem_slave

Overview:
- Parametrised SPI-slave memory: SPI mode 0 front end, command FSM, and an internal register-array memory of 2**ADDR_W words of DATA_W bits.
- Sits between the board SPI pins and the debug LEDs, as the next-generation SPI memory block.
- Adds over the previous block: configurable address and data widths, internal edge detection, CS-abort handling, status outputs, and optional burst transfers with address auto-increment.

Parameters:
ADDR_W, 7, address bits per command; memory depth = 2**ADDR_W
DATA_W, 8, data word width in bits
SYNC_STAGES, 2, synchroniser flops per SPI input (min 2)

Ports:
clk  input  1  FPGA system clock
reset_n  input  1  asynchronous active-low reset
sclk_pin  input  1  SPI clock from master, idle low (CPOL=0)
cs_pin  input  1  SPI chip select, active low
mosi_pin  input  1  master out, slave in
miso_pin  output  1  slave out; driven 0 when miso_oe=0
miso_oe  output  1  MISO drive enable, for an external tristate
busy  output  1  high whenever synchronised CS is low
leds  output  4  debug: {miso_oe, state[2:0]}

Behaviour:
- Interface (already decided): one clock, clk; reset_n is asynchronous and active-low.
- Reset values: miso_pin=0, miso_oe=0, busy=0, state=IDLE, address/shift/bit counters=0. Memory contents are not reset.
- Inputs pass through SYNC_STAGES flops. Rising/falling SCLK edges are detected as one-clk pulses: pin edge to pulse = SYNC_STAGES+1 clk.
- SCLK high and low phases must each be at least SYNC_STAGES+2 clk. No debounce.
- Protocol, all fields MSB first:
  - Command frame of ADDR_W+1 bits = address, then R/W flag (1 = read, 0 = write).
  - Then DATA_W-bit data words.
  - MOSI is sampled on SCLK rising edges; MISO changes on SCLK falling edges.
- FSM states:
  - IDLE: wait for synced CS low -> GET_CMD; bit counter cleared.
  - GET_CMD: shift MOSI each rise. On rise ADDR_W+1, latch address: flag=1 -> RD_LOAD, flag=0 -> WR_SHIFT.
  - RD_LOAD: one clk; shift register <= mem[addr], miso_oe=1 -> RD_SHIFT.
  - RD_SHIFT:
    - Each SCLK fall drives the next bit, the MSB on the first fall after the flag bit.
    - After DATA_W bits have been driven, at the next fall: burst -> addr+1, RD_LOAD-equivalent reload in the same clk, continue; non-burst -> DONE.
  - WR_SHIFT: shift MOSI each rise. On rise DATA_W -> WR_COMMIT.
  - WR_COMMIT: one clk; mem[addr] <= shift register. Then burst -> addr+1, WR_SHIFT; non-burst -> DONE.
  - DONE: miso_oe=0; ignore SCLK until CS high.
- CS deasserted (synced) in any state:
  - -> IDLE the next clk; miso_oe=0 in that same clk.
  - Partial write word discarded; memory untouched.
  - A WR_COMMIT already in progress completes.
- Address auto-increment wraps modulo 2**ADDR_W (all-ones -> 0).
- SCLK edges while CS high are ignored. CS low with no SCLK holds state indefinitely.
- reset_n low at any time: immediate return to reset values; any in-flight write is lost; memory otherwise retained.
- Read of a never-written location returns an undefined value; the bench must not check it.

Optional Feature:
SPI_MEM_BURST_EN:
- Defined: after each data word the FSM stays in the transfer, auto-incrementing the address per word until CS rises.
- Undefined: exactly one data word per CS assertion; further SCLK edges are ignored in DONE, MISO held 0 with miso_oe=0.

Test Plan:
1. Write: CS low, shift 0x24 (addr 0x12, W), then 0x5A, CS high -> mem[0x12]=0x5A; busy high throughout CS low; miso_oe stays 0.
2. Readback: CS low, shift 0x25 (addr 0x12, R), 8 SCLK -> MISO bits 0,1,0,1,1,0,1,0 (0x5A) sampled on rises; miso_oe high only during data phase.
3. Burst (SPI_MEM_BURST_EN): write 0x20 (addr 0x10), data 0xA1, 0xB2 -> mem[0x10]=0xA1, mem[0x11]=0xB2. Read 0x23 (addr 0x11) -> 0xB2.
4. Wrap (SPI_MEM_BURST_EN): preload mem[0x7F]=0x3C, mem[0x00]=0xC3. Burst read 0xFF, 16 SCLK -> 0x3C then 0xC3.
5. Abort: mem[0x20]=0x11. Write cmd 0x40, then 4 data bits 1111, CS high -> mem[0x20]=0x11; state IDLE within SYNC_STAGES+2 clk.
6. Reset mid-read: assert reset_n low during RD_SHIFT -> miso_oe=0, miso_pin=0, leds=0 same cycle. After release, a read of 0x12 still returns 0x5A.
